// File: rtl/pipeline_stall_flush_controller.sv
// rtl/pipeline_stall_flush_controller.sv - per-stage stall/flush control with halt/drain and perf counters
//
// Purpose: turns load-use and taken-branch hazards, multi-cycle FP occupancy of EX and
//          halt/resume requests into write-enable and flush controls for the PC, IF/ID,
//          ID/EX and EX/MEM pipeline registers, and counts stall and flush cycles.
// Ports:
//   clock, reset                          clock (rising edge), asynchronous active-high reset
//   hazard_load_instruction_indicator     load-use hazard between ID and EX
//   hazard_branch_is_taken_indicator      branch resolved taken this cycle
//   fp_multicycle_start_EXEStage          one-cycle pulse, multi-cycle FP op entered EX
//   halt_request / resume_request         drain-and-halt / leave-halted pulses
//   pc_write_enable ... EX_MEM_flush      combinational pipeline register controls
//   halted                                registered, pipeline drained and frozen
//   stall_cycle_count, flush_count        saturating performance counters
module pipeline_stall_flush_controller #(
    parameter int FP_LATENCY    = 4,
    parameter int PIPE_DEPTH    = 5,
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     hazard_load_instruction_indicator,
    input  logic                     hazard_branch_is_taken_indicator,
    input  logic                     fp_multicycle_start_EXEStage,
    input  logic                     halt_request,
    input  logic                     resume_request,
    output logic                     pc_write_enable,
    output logic                     IF_ID_write_enable,
    output logic                     IF_ID_flush,
    output logic                     ID_EX_write_enable,
    output logic                     ID_EX_flush,
    output logic                     EX_MEM_flush,
    output logic                     halted,
    output logic [COUNTER_WIDTH-1:0] stall_cycle_count,
    output logic [COUNTER_WIDTH-1:0] flush_count
);

    localparam int DW = $clog2(PIPE_DEPTH) + 1;
    localparam logic [DW-1:0] DRAIN_INIT = DW'(PIPE_DEPTH - 1);
    // FP_WAIT covers the stall cycles after the start cycle: FP_LATENCY-2 of them.
    localparam logic [3:0] FP_WAIT_CYCLES = 4'(FP_LATENCY - 2);
    localparam bit FP_STALLS = (FP_LATENCY > 1);
    localparam bit FP_WAITS  = (FP_LATENCY > 2);
    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = {COUNTER_WIDTH{1'b1}};

    typedef enum logic [1:0] {S_RUN, S_FP_WAIT, S_DRAIN, S_HALTED} state_t;

    state_t          state;
    state_t          ret_state;
    logic [3:0]      fp_cnt;
    logic [DW-1:0]   drain_cnt;

    logic active;
    logic ev_branch;
    logic ev_fp;
    logic ev_load;
    logic stall_cycle;

    // Events are only acted on in RUN and DRAIN; priority branch > FP > load.
    assign active      = (state == S_RUN) || (state == S_DRAIN);
    assign ev_branch   = active && hazard_branch_is_taken_indicator;
    assign ev_fp       = active && !hazard_branch_is_taken_indicator
                         && fp_multicycle_start_EXEStage && FP_STALLS;
    assign ev_load     = active && !hazard_branch_is_taken_indicator && !ev_fp
                         && hazard_load_instruction_indicator;
    assign stall_cycle = ev_fp || ev_load || (state == S_FP_WAIT);

    always_comb begin
        pc_write_enable    = 1'b1;
        IF_ID_write_enable = 1'b1;
        IF_ID_flush        = 1'b0;
        ID_EX_write_enable = 1'b1;
        ID_EX_flush        = 1'b0;
        EX_MEM_flush       = 1'b0;
        case (state)
            S_RUN, S_DRAIN: begin
                if (ev_branch) begin
                    IF_ID_flush = 1'b1;
                    ID_EX_flush = 1'b1;
                end else if (ev_fp) begin
                    pc_write_enable    = 1'b0;
                    IF_ID_write_enable = 1'b0;
                    ID_EX_write_enable = 1'b0;
                    EX_MEM_flush       = 1'b1;
                end else if (ev_load) begin
                    pc_write_enable    = 1'b0;
                    IF_ID_write_enable = 1'b0;
                    ID_EX_flush        = 1'b1;
                end else if (state == S_DRAIN) begin
                    // Stop fetching; older instructions keep flowing out.
                    pc_write_enable = 1'b0;
                    IF_ID_flush     = 1'b1;
                end
            end
            S_FP_WAIT: begin
                pc_write_enable    = 1'b0;
                IF_ID_write_enable = 1'b0;
                ID_EX_write_enable = 1'b0;
                EX_MEM_flush       = 1'b1;
            end
            default: begin
                pc_write_enable    = 1'b0;
                IF_ID_write_enable = 1'b0;
                ID_EX_write_enable = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= S_RUN;
            ret_state         <= S_RUN;
            fp_cnt            <= 4'd0;
            drain_cnt         <= '0;
            halted            <= 1'b0;
            stall_cycle_count <= '0;
            flush_count       <= '0;
        end else begin
            if (stall_cycle && stall_cycle_count != CNT_MAX)
                stall_cycle_count <= stall_cycle_count + COUNTER_WIDTH'(1);
            if (ev_branch && flush_count != CNT_MAX)
                flush_count <= flush_count + COUNTER_WIDTH'(1);

            case (state)
                S_RUN, S_DRAIN: begin
                    if (ev_fp) begin
                        // With FP_LATENCY==2 the start cycle is the only stall: stay put.
                        if (FP_WAITS) begin
                            state     <= S_FP_WAIT;
                            ret_state <= state;
                            fp_cnt    <= FP_WAIT_CYCLES;
                        end
                    end else if (ev_load) begin
                        // Single-cycle stall, drain count frozen.
                    end else if (state == S_DRAIN) begin
                        // Base drain cycle or branch: the drain count advances.
                        drain_cnt <= drain_cnt - DW'(1);
                        if (drain_cnt == DW'(1)) begin
                            state  <= S_HALTED;
                            halted <= 1'b1;
                        end
                    end else if (!ev_branch && halt_request) begin
                        state     <= S_DRAIN;
                        drain_cnt <= DRAIN_INIT;
                    end
                end
                S_FP_WAIT: begin
                    if (fp_cnt == 4'd1)
                        state <= ret_state;
                    else
                        fp_cnt <= fp_cnt - 4'd1;
                end
                S_HALTED: begin
                    if (resume_request) begin
                        state  <= S_RUN;
                        halted <= 1'b0;
                    end
                end
                default: state <= S_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_stall_flush_controller.sv
// tb/tb_pipeline_stall_flush_controller.sv - scoreboard bench for pipeline_stall_flush_controller
module tb_pipeline_stall_flush_controller;

    localparam int FPL = 4;
    localparam int PD  = 5;
    localparam int SMALL_MAX = 7;

    logic clock = 1'b0;
    logic reset;
    logic ld, br, fp, hr, rs;
    logic pc_we, ifid_we, ifid_fl, idex_we, idex_fl, exmem_fl, halted;
    logic [31:0] stall_cnt, flush_cnt;
    logic pc_we_s, ifid_we_s, ifid_fl_s, idex_we_s, idex_fl_s, exmem_fl_s, halted_s;
    logic [2:0] stall_cnt_s, flush_cnt_s;

    always #5 clock = ~clock;

    pipeline_stall_flush_controller #(.FP_LATENCY(FPL), .PIPE_DEPTH(PD), .COUNTER_WIDTH(32)) dut (
        .clock(clock), .reset(reset),
        .hazard_load_instruction_indicator(ld),
        .hazard_branch_is_taken_indicator(br),
        .fp_multicycle_start_EXEStage(fp),
        .halt_request(hr), .resume_request(rs),
        .pc_write_enable(pc_we), .IF_ID_write_enable(ifid_we), .IF_ID_flush(ifid_fl),
        .ID_EX_write_enable(idex_we), .ID_EX_flush(idex_fl), .EX_MEM_flush(exmem_fl),
        .halted(halted), .stall_cycle_count(stall_cnt), .flush_count(flush_cnt)
    );

    // Narrow-counter copy on the same stimulus, to reach counter saturation.
    pipeline_stall_flush_controller #(.FP_LATENCY(FPL), .PIPE_DEPTH(PD), .COUNTER_WIDTH(3)) dut_small (
        .clock(clock), .reset(reset),
        .hazard_load_instruction_indicator(ld),
        .hazard_branch_is_taken_indicator(br),
        .fp_multicycle_start_EXEStage(fp),
        .halt_request(hr), .resume_request(rs),
        .pc_write_enable(pc_we_s), .IF_ID_write_enable(ifid_we_s), .IF_ID_flush(ifid_fl_s),
        .ID_EX_write_enable(idex_we_s), .ID_EX_flush(idex_fl_s), .EX_MEM_flush(exmem_fl_s),
        .halted(halted_s), .stall_cycle_count(stall_cnt_s), .flush_count(flush_cnt_s)
    );

    typedef struct {
        int          cyc;
        logic [5:0]  ctrl;   // {pc_we, IF_ID_we, IF_ID_flush, ID_EX_we, ID_EX_flush, EX_MEM_flush}
        logic        halted;
        int unsigned stalls;
        int unsigned flushes;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: remaining forced FP stall cycles, drain progress, halted flag, counts.
    int          m_fp_left;
    bit          m_draining;
    int          m_drain_left;
    bit          m_halted;
    int unsigned m_stalls;
    int unsigned m_flushes;

    task automatic model_reset();
        m_fp_left = 0; m_draining = 0; m_drain_left = 0; m_halted = 0;
        m_stalls = 0; m_flushes = 0;
    endtask

    localparam logic [5:0] IDLE  = 6'b110100;
    localparam logic [5:0] FPST  = 6'b000001;
    localparam logic [5:0] LOADS = 6'b000110;
    localparam logic [5:0] BRAN  = 6'b111110;
    localparam logic [5:0] DRNB  = 6'b011100;
    localparam logic [5:0] HALT  = 6'b000000;

    task automatic model_step(input bit b, input bit f, input bit l, input bit h, input bit r);
        exp_t e;
        e.cyc = cyc; e.halted = m_halted; e.stalls = m_stalls; e.flushes = m_flushes;
        e.ctrl = IDLE;
        if (m_fp_left > 0) begin
            e.ctrl = FPST; m_stalls++; m_fp_left--;
        end else if (m_halted) begin
            e.ctrl = HALT;
            if (r) m_halted = 0;
        end else if (b) begin
            e.ctrl = BRAN; m_flushes++;
            if (m_draining) begin
                m_drain_left--;
                if (m_drain_left == 0) begin m_draining = 0; m_halted = 1; end
            end
        end else if (f && FPL > 1) begin
            e.ctrl = FPST; m_stalls++; m_fp_left = FPL - 2;
        end else if (l) begin
            e.ctrl = LOADS; m_stalls++;
        end else if (m_draining) begin
            e.ctrl = DRNB; m_drain_left--;
            if (m_drain_left == 0) begin m_draining = 0; m_halted = 1; end
        end else if (h) begin
            m_draining = 1; m_drain_left = PD - 1;
        end
        sb.push_back(e);
    endtask

    task automatic cycle(input bit b, input bit f, input bit l, input bit h, input bit r);
        @(posedge clock); #1;
        cyc++;
        br = b; fp = f; ld = l; hr = h; rs = r;
        model_step(b, f, l, h, r);
    endtask

    // Asynchronous reset in the middle of a cycle: outputs and counters clear at once.
    task automatic reset_cycle();
        exp_t e;
        @(posedge clock); #1;
        cyc++;
        br = 0; fp = 0; ld = 0; hr = 0; rs = 0;
        reset = 1'b1;
        model_reset();
        e.cyc = cyc; e.ctrl = IDLE; e.halted = 0; e.stalls = 0; e.flushes = 0;
        sb.push_back(e);
        @(posedge clock); #1;
        cyc++;
        reset = 1'b0;
        e.cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h required %0h", name, c, act, req);
        end
    endtask

    function automatic logic [31:0] sat(input int unsigned v);
        return (v > SMALL_MAX) ? 32'(SMALL_MAX) : 32'(v);
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("ctrl", e.cyc, 32'({pc_we, ifid_we, ifid_fl, idex_we, idex_fl, exmem_fl}), 32'(e.ctrl));
                check("halted", e.cyc, 32'(halted), 32'(e.halted));
                check("stall_cycle_count", e.cyc, stall_cnt, e.stalls);
                check("flush_count", e.cyc, flush_cnt, e.flushes);
                check("ctrl_small", e.cyc, 32'({pc_we_s, ifid_we_s, ifid_fl_s, idex_we_s, idex_fl_s, exmem_fl_s}), 32'(e.ctrl));
                check("stall_sat", e.cyc, 32'(stall_cnt_s), sat(e.stalls));
                check("flush_sat", e.cyc, 32'(flush_cnt_s), sat(e.flushes));
            end
        end
    end

    initial begin : stimulus
        br = 0; fp = 0; ld = 0; hr = 0; rs = 0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        repeat (10) cycle(0, 0, 0, 0, 0);          // idle after reset
        cycle(0, 0, 1, 0, 0);                      // load stall
        repeat (2) cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);                      // FP start: three stall cycles
        repeat (5) cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 1, 0, 0);                      // branch beats load
        repeat (2) cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);                      // halt request
        cycle(0, 0, 0, 0, 0);                      // drain cycle 1
        cycle(0, 0, 1, 0, 0);                      // drain cycle 2 with load
        repeat (5) cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);                      // resume
        repeat (3) cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 0, 1, 0);                      // halt loses to branch
        cycle(0, 0, 0, 1, 0);                      // halt, then FP inside drain
        cycle(0, 1, 0, 0, 0);
        repeat (8) cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 1, 0, 0, 0);                      // FP start, then reset in FP_WAIT
        reset_cycle();
        repeat (3) cycle(0, 0, 0, 0, 0);

        for (int i = 0; i < 800; i++)
            cycle(($urandom % 8) == 0, ($urandom % 12) == 0, ($urandom % 5) == 0,
                  ($urandom % 15) == 0, ($urandom % 4) == 0);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clock);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
